// File: rtl/inv_addkey_mixcol_pkg.sv
// Shared AES constants and the state encoding for the inverse AddRoundKey/InvMixColumns stage.
package inv_addkey_mixcol_pkg;

   localparam int unsigned NB      = 4;
   localparam int unsigned STATE_W = 128;
   localparam int unsigned WORD_W  = STATE_W / NB;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MIX,
      ST_DONE
   } state_e;

endpackage

// File: rtl/inv_addkey_mixcol_invmix.sv
// InvMixColumns on one 32-bit column; byte 0 sits in bits [0:7].
module invMix (
   input  logic [0:31] word_in,
   output logic [0:31] word_out
);

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   logic [7:0] a  [4];
   logic [7:0] m9 [4];
   logic [7:0] mb [4];
   logic [7:0] md [4];
   logic [7:0] me [4];

   always_comb begin
      for (int unsigned i = 0; i < 4; i++) begin
         logic [7:0] x2, x4, x8;
         a[i]  = word_in[8*i +: 8];
         x2    = xtime(a[i]);
         x4    = xtime(x2);
         x8    = xtime(x4);
         m9[i] = x8 ^ a[i];
         mb[i] = x8 ^ x2 ^ a[i];
         md[i] = x8 ^ x4 ^ a[i];
         me[i] = x8 ^ x4 ^ x2;
      end
      word_out[0:7]   = me[0] ^ mb[1] ^ md[2] ^ m9[3];
      word_out[8:15]  = m9[0] ^ me[1] ^ mb[2] ^ md[3];
      word_out[16:23] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
      word_out[24:31] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
   end

endmodule

// File: rtl/inv_addkey_mixcol.sv
// Inverse-round back half: AddRoundKey on accept, then InvMixColumns over MIX_LANES columns per cycle.
module inv_addkey_mixcol
   import inv_addkey_mixcol_pkg::*;
#(
   parameter int unsigned MIX_LANES = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [0:STATE_W-1] state_in,
   input  logic [0:STATE_W-1] round_key,
   input  logic               last_round,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [0:STATE_W-1] state_out,
   output logic               busy
);

   if (!(MIX_LANES == 1 || MIX_LANES == 2 || MIX_LANES == 4)) begin : g_bad_lanes
      $error("inv_addkey_mixcol: MIX_LANES must be 1, 2 or 4");
   end

   state_e             state_q, state_d;
   logic [1:0]         col_q, col_d;
   logic [0:STATE_W-1] work_q, work_d;
   logic               last_q, last_d;

   logic [1:0]         lane_col [MIX_LANES];
   logic [0:WORD_W-1]  mix_in   [MIX_LANES];
   logic [0:WORD_W-1]  mix_out  [MIX_LANES];

   for (genvar l = 0; l < MIX_LANES; l++) begin : g_lane
      assign lane_col[l] = col_q + 2'(l);
      assign mix_in[l]   = work_q[WORD_W*lane_col[l] +: WORD_W];
      invMix u_inv_mix (
         .word_in  (mix_in[l]),
         .word_out (mix_out[l])
      );
   end

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      work_d  = work_q;
      last_d  = last_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               work_d  = state_in ^ round_key;
               last_d  = last_round;
               col_d   = '0;
               state_d = last_round ? ST_DONE : ST_MIX;
            end
         end
         ST_MIX: begin
            for (int unsigned l = 0; l < MIX_LANES; l++) begin
               work_d[WORD_W*lane_col[l] +: WORD_W] = mix_out[l];
            end
            col_d = col_q + 2'(MIX_LANES);
            // The highest lane reaching column 3 marks the final MIX edge.
            if (last_q || lane_col[MIX_LANES-1] == 2'd3) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         col_q   <= '0;
         work_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         work_q  <= work_d;
         last_q  <= last_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q != ST_IDLE);
   assign state_out = (state_q == ST_DONE) ? work_q : '0;

endmodule

// File: tb/tb_inv_addkey_mixcol.sv
// Directed checks for inv_addkey_mixcol with one lane (index 0) and four lanes (index 1).
module tb_inv_addkey_mixcol;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [1:0]   iv, ir, ov, orr, bz;
   logic [0:127] st_in, rk;
   logic         lr;
   logic [0:127] so [2];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   inv_addkey_mixcol #(.MIX_LANES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
      .state_in(st_in), .round_key(rk), .last_round(lr),
      .out_valid(ov[0]), .out_ready(orr[0]), .state_out(so[0]), .busy(bz[0])
   );

   inv_addkey_mixcol #(.MIX_LANES(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
      .state_in(st_in), .round_key(rk), .last_round(lr),
      .out_valid(ov[1]), .out_ready(orr[1]), .state_out(so[1]), .busy(bz[1])
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Offer one job to DUT s, measure edges from accept to out_valid, hold DONE for `hold` cycles.
   task automatic run_job(input int s, input logic [0:127] st, input logic [0:127] key,
                          input logic last, input logic [0:127] exp, input int exp_lat,
                          input int hold, input string tag);
      int lat;
      st_in = st;
      rk    = key;
      lr    = last;
      check({tag, ".in_ready"}, 128'(ir[s]), 128'd1);
      iv[s] = 1'b1;
      @(posedge clk); #1;
      iv[s] = 1'b0;
      st_in = ~st;
      rk    = {4{32'hdeadbeef}};
      lr    = ~last;
      lat = 0;
      while (!ov[s] && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, ".latency"}, 128'(lat), 128'(exp_lat));
      check({tag, ".state_out"}, so[s], exp);
      for (int i = 0; i < hold; i++) begin
         check({tag, ".hold_valid"}, 128'(ov[s]), 128'd1);
         check({tag, ".hold_data"}, so[s], exp);
         check({tag, ".hold_in_ready"}, 128'(ir[s]), 128'd0);
         iv[s] = 1'b1;
         st_in = {$urandom, $urandom, $urandom, $urandom};
         lr    = i[0];
         @(posedge clk); #1;
         iv[s] = 1'b0;
      end
      orr[s] = 1'b1;
      @(posedge clk); #1;
      orr[s] = 1'b0;
      check({tag, ".valid_drop"}, 128'(ov[s]), 128'd0);
      check({tag, ".in_ready_back"}, 128'(ir[s]), 128'd1);
      check({tag, ".busy_idle"}, 128'(bz[s]), 128'd0);
   endtask

   localparam logic [0:127] MC_IN   = {4{32'h046681e5}};
   localparam logic [0:127] MC_OUT  = {4{32'hd4bf5d30}};
   localparam logic [0:127] FIPS_MX = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
   localparam logic [0:127] FIPS_PL = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
   localparam logic [0:127] FIPS_K  = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
   localparam logic [0:127] LR_ST   = 128'h00112233_44556677_8899aabb_ccddeeff;
   localparam logic [0:127] LR_K    = 128'h00010203_04050607_08090a0b_0c0d0e0f;
   localparam logic [0:127] LR_OUT  = 128'h00102030_40506070_8090a0b0_c0d0e0f0;

   initial begin
      logic [0:127] rnd;
      iv = '0; orr = '0; st_in = '0; rk = '0; lr = 1'b0;
      #12;
      for (int s = 0; s < 2; s++) begin
         check("reset.out_valid", 128'(ov[s]), 128'd0);
         check("reset.busy", 128'(bz[s]), 128'd0);
         check("reset.state_out", so[s], 128'd0);
         check("reset.in_ready", 128'(ir[s]), 128'd1);
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      run_job(0, MC_IN, '0, 1'b0, MC_OUT, 4, 0, "l1_mix");
      run_job(0, LR_ST, LR_K, 1'b1, LR_OUT, 0, 0, "l1_last");
      rnd = {$urandom, $urandom, $urandom, $urandom};
      run_job(0, rnd, rnd, 1'b0, '0, 4, 0, "l1_selfkey");
      run_job(0, FIPS_MX ^ FIPS_K, FIPS_K, 1'b0, FIPS_PL, 4, 0, "l1_fips");
      run_job(0, MC_IN, '0, 1'b0, MC_OUT, 4, 5, "l1_backpressure");

      st_in = FIPS_MX; rk = '0; lr = 1'b0;
      iv[0] = 1'b1;
      @(posedge clk); #1;
      iv[0] = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("midreset.out_valid", 128'(ov[0]), 128'd0);
      check("midreset.busy", 128'(bz[0]), 128'd0);
      check("midreset.state_out", so[0], 128'd0);
      check("midreset.in_ready", 128'(ir[0]), 128'd1);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      run_job(0, MC_IN, '0, 1'b0, MC_OUT, 4, 0, "l1_after_reset");

      run_job(1, MC_IN, '0, 1'b0, MC_OUT, 1, 0, "l4_mix");
      run_job(1, LR_ST, LR_K, 1'b1, LR_OUT, 0, 0, "l4_last");
      run_job(1, FIPS_MX ^ FIPS_K, FIPS_K, 1'b0, FIPS_PL, 1, 2, "l4_fips");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
